hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
Pipeline hazard and sequencing controller for the 5-stage CPU. It owns the stall, flush and freeze controls of the IF/ID and ID/EX stage registers and the PC.
- Detects load-use hazards between ID and EX and inserts one bubble into ID/EX.
- Flushes the wrong path on a branch taken in EX.
- Freezes the whole pipe while data memory is busy.
- Drains the pipe on a decoded halt, then holds the CPU halted.
- Keeps saturating stall and flush performance counters.

Parameters:
LOAD_SEL, 2'b01, Mem2RegSEL encoding that marks a load (memory data to register)
DRAIN_CYCLES, 4, cycles after halt leaves ID before Halted asserts (EX, MEM, WB, plus margin)
CNT_W, 32, width of the performance counters

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  reset, synchronous, active-high
ID_RSAddr  in  5  rs field of the instruction in ID
ID_RTAddr  in  5  rt field of the instruction in ID
ID_UsesRS  in  1  ID instruction reads rs
ID_UsesRT  in  1  ID instruction reads rt
ID_Halt  in  1  ID instruction is a halt
EX_RegWriteEN  in  1  EX instruction writes the register file
EX_Mem2RegSEL  in  2  EX instruction writeback select
EX_DstAddr  in  5  EX destination register, after the RegDst mux
EX_BranchTaken  in  1  beq/bne resolved taken in EX this cycle
MEM_Busy  in  1  data memory not ready; the access must hold
PCWriteEN  out  1  PC update enable
IFIDWriteEN  out  1  IF/ID load enable
IFIDFlush  out  1  IF/ID load a NOP
IDEXFlush  out  1  ID/EX load a bubble (all control enables 0)
Freeze  out  1  hold EX/MEM and MEM/WB and suppress register-file and memory writes
Halted  out  1  CPU halted
StallCount  out  CNT_W  cycles lost to load-use stall or memory freeze
FlushCount  out  CNT_W  taken-branch flush events

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of CLOCK.
  - RESET is synchronous and active-high: state=RUN, drain counter=0, StallCount=0, FlushCount=0, Halted=0.
  - While RESET=1, the combinational outputs are forced to: PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=1, IDEXFlush=1, Freeze=0.
  - Reset asserted mid-drain or while halted returns the block to RUN on the next edge.
- Control outputs are combinational (Mealy) from state and inputs, with zero-cycle latency. Counters and Halted are registered.
- Load-use hazard LU = EX_RegWriteEN & (EX_Mem2RegSEL==LOAD_SEL) & (EX_DstAddr!=0) & ((ID_UsesRS & EX_DstAddr==ID_RSAddr) | (ID_UsesRT & EX_DstAddr==ID_RTAddr)).
- Priority in RUN, highest first:
  1. MEM_Busy: Freeze=1, PCWriteEN=0, IFIDWriteEN=0, flushes=0. Every register holds. StallCount+1.
  2. EX_BranchTaken: PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=1, IDEXFlush=1. FlushCount+1. LU and ID_Halt are ignored because the ID instruction is on the wrong path.
  3. LU: PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1, IFIDFlush=0. StallCount+1. Exactly one bubble; the next cycle re-evaluates LU, which is naturally 0 once the load is in MEM.
  4. ID_Halt: the halt advances to EX; PCWriteEN=0, IFIDFlush=1. Drain counter loads DRAIN_CYCLES-1 and next state is DRAIN.
  5. Otherwise: PCWriteEN=1, IFIDWriteEN=1, all flushes 0, Freeze=0.
- DRAIN:
  - PCWriteEN=0, IFIDWriteEN=1, IFIDFlush=1, IDEXFlush=1; bubbles fill behind the halt.
  - MEM_Busy=1: Freeze as in RUN, drain counter holds, StallCount+1.
  - Otherwise the counter decrements. When the counter reads 0 and the cycle is not frozen, next state is HALTED.
  - EX_BranchTaken and LU are don't-care in DRAIN; only bubbles are in flight.
- HALTED: Halted=1; PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=1, IDEXFlush=1, Freeze=0. Exit only through RESET.
- Counters saturate at all-ones and never wrap. Both counters hold their values in HALTED.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state enum (RUN, DRAIN, HALTED; 2-bit encoding);
  - the Mem2RegSEL encodings, including LOAD_SEL;
  - the REG_ZERO constant.
- One combinational sub-module, load_use_detect, computes LU from the ID and EX fields. The FSM, drain counter and counters stay in the top.

Test Plan:
- RESET=1 for 2 cycles, then 0 with idle inputs -> during reset PCWriteEN=0 and both flushes=1. After reset PCWriteEN=1, IFIDWriteEN=1, counters 0, Halted=0.
- EX is lw $8 (RegWriteEN=1, Mem2RegSEL=01, Dst=8); ID is add using rs=8 -> one cycle of PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1, StallCount=1. Next cycle (EX bubble) runs normally. Repeat with Dst=0 -> no stall.
- EX_BranchTaken=1 and LU=1 in the same cycle -> IFIDFlush=1, IDEXFlush=1, PCWriteEN=1, FlushCount=1, StallCount unchanged.
- MEM_Busy=1 for 3 cycles while LU=1 -> Freeze=1 and all enables 0 for 3 cycles, StallCount=3. After release, the LU bubble is inserted and StallCount=4.
- ID_Halt=1 in RUN with DRAIN_CYCLES=4 -> DRAIN for 4 cycles, Halted=1 on the 5th edge. With MEM_Busy=1 for 2 cycles mid-drain -> Halted is delayed by 2 cycles. RESET while HALTED -> RUN, Halted=0.
- Force StallCount to all-ones (CNT_W=4 build) and continue stalling -> the count holds at 4'hF.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and writeback/register constants for the CPU control path
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;
  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] LOAD_SEL = 2'b01;
  localparam logic [1:0] M2R_PC   = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading a register still being loaded by EX
module load_use_detect
  import cpu_ctrl_pkg::*;
#(
  parameter logic [1:0] LOAD_SEL_P = LOAD_SEL
) (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_we,
  input  logic [1:0] ex_m2r,
  input  logic [4:0] ex_dst,
  output logic       lu
);
  always_comb
    lu = ex_we && ex_m2r == LOAD_SEL_P && ex_dst != REG_ZERO &&
         ((id_uses_rs && ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush/freeze sequencing of the 5-stage pipe, halt drain and perf counters
module hazard_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [1:0] LOAD_SEL     = cpu_ctrl_pkg::LOAD_SEL,
  parameter int         DRAIN_CYCLES = 4,
  parameter int         CNT_W        = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [4:0]       ID_RSAddr,
  input  logic [4:0]       ID_RTAddr,
  input  logic             ID_UsesRS,
  input  logic             ID_UsesRT,
  input  logic             ID_Halt,
  input  logic             EX_RegWriteEN,
  input  logic [1:0]       EX_Mem2RegSEL,
  input  logic [4:0]       EX_DstAddr,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Busy,
  output logic             PCWriteEN,
  output logic             IFIDWriteEN,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Freeze,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_e state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic lu, stall_inc, flush_inc;
  load_use_detect #(.LOAD_SEL_P(LOAD_SEL)) u_lu (
    .id_rs(ID_RSAddr),
    .id_rt(ID_RTAddr),
    .id_uses_rs(ID_UsesRS),
    .id_uses_rt(ID_UsesRT),
    .ex_we(EX_RegWriteEN),
    .ex_m2r(EX_Mem2RegSEL),
    .ex_dst(EX_DstAddr),
    .lu(lu)
  );
  always_ff @(posedge CLOCK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    stall_q <= RESET ? '0 : stall_d;
    flush_q <= RESET ? '0 : flush_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (RESET) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      if (!MEM_Busy && !EX_BranchTaken && !lu && ID_Halt) begin
        state_d = DRAIN;
        cnt_d   = DW'(DRAIN_CYCLES - 1);
      end
    end else if (state_q == DRAIN && !MEM_Busy) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? HALTED : DRAIN;
    end
  end
  // Defaults are the parked (reset/halted) values; the freeze case clears everything but Freeze.
  always_comb begin
    PCWriteEN   = 1'b0;
    IFIDWriteEN = 1'b0;
    IFIDFlush   = 1'b1;
    IDEXFlush   = 1'b1;
    Freeze      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!RESET && state_q != HALTED) begin
      if (MEM_Busy) begin
        Freeze    = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        stall_inc = 1'b1;
      end else if (state_q == DRAIN) begin
        IFIDWriteEN = 1'b1;
      end else if (EX_BranchTaken) begin
        PCWriteEN   = 1'b1;
        IFIDWriteEN = 1'b1;
        flush_inc   = 1'b1;
      end else if (lu) begin
        IFIDFlush = 1'b0;
        stall_inc = 1'b1;
      end else if (ID_Halt) begin
        IFIDWriteEN = 1'b1;
        IDEXFlush   = 1'b0;
      end else begin
        PCWriteEN   = 1'b1;
        IFIDWriteEN = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
      end
    end
  end
  always_comb begin
    stall_d = stall_inc && !(&stall_q) ? stall_q + 1'b1 : stall_q;
    flush_d = flush_inc && !(&flush_q) ? flush_q + 1'b1 : flush_q;
  end
  assign Halted     = state_q == HALTED;
  assign StallCount = stall_q;
  assign FlushCount = flush_q;
endmodule
